axi4_mm_decoupler: RTL and testbench
====================================

Name: axi4_mm_decoupler

Overview:
- AXI4-MM isolation stage placed directly upstream of a reconfigurable or untrusted slave region.
- In RUN it is a zero-latency pass-through that counts outstanding write and read transactions.
- On request it stops new address beats, drains in-flight bursts, then fully isolates both sides and reports completion.
- Protocol-legal on both sides throughout, so software can swap, or error-terminate, the downstream region safely.

Parameters:
- AXI_ID_WIDTH, 4, ID width on all channels.
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 32, data width (any multiple of 8).
- OUTSTANDING_WREQ, 8, maximum accepted AW bursts whose B response is not yet returned.
- OUTSTANDING_RREQ, 8, maximum accepted AR bursts whose final R beat is not yet returned.

Ports:
- aclk  in  1  clock; all interfaces synchronous to it.
- aresetn  in  1  synchronous active-low reset.
- decouple  in  1  level request to isolate the downstream slave.
- decouple_done  out  1  high while fully isolated.
- axi_s_aw{id,addr,len,size,burst,valid}  in  ID/ADDR/8/3/2/1  upstream write address; axi_s_awready  out  1.
- axi_s_w{data,strb,last,valid}  in  DATA/DATA/8/1/1  upstream write data; axi_s_wready  out  1.
- axi_s_b{id,resp,valid}  out  ID/2/1  upstream write response; axi_s_bready  in  1.
- axi_s_ar{id,addr,len,size,burst,valid}  in  as AW; axi_s_arready  out  1.
- axi_s_r{id,data,resp,last,valid}  out  ID/DATA/2/1/1  upstream read data; axi_s_rready  in  1.
- axi_m_*  mirror set of all five channels with directions reversed, toward the downstream slave.

Behaviour:
- Payload fields pass straight through combinationally on every channel. Only valid and ready are gated. Zero added latency.
- Counters (unsigned, $clog2(MAX+1) bits, reset 0):
  - outst_w: +1 on upstream AW handshake, -1 on B handshake.
  - w_owed: +1 on AW handshake, -1 on W handshake with wlast.
  - outst_r: +1 on AR handshake, -1 on R handshake with rlast.
  - Increment and decrement in the same cycle leave the counter unchanged.
- AW accepted only if outst_w < OUTSTANDING_WREQ. AR accepted only if outst_r < OUTSTANDING_RREQ.
- W is forwarded only while w_owed > 0 or an AW handshake occurs in the same cycle. W-before-AW is not supported.
- aw_hold / ar_hold registers: set when axi_m_awvalid && !axi_m_awready (resp. AR) at a clock edge, cleared otherwise. They guarantee a presented downstream valid is never withdrawn.
- FSM, reset state RUN:
  - RUN: all channels pass, subject to the gating above. decouple=1 moves to DRAIN.
  - DRAIN: axi_s_awready = axi_s_arready = 0. axi_m_awvalid / axi_m_arvalid pass only while aw_hold / ar_hold is set; that pending handshake completes and is counted. W, B and R pass normally. When outst_w == 0, w_owed == 0, outst_r == 0 and neither hold is set, move to DECOUPLED. decouple=0 returns to RUN next cycle.
  - DECOUPLED: every valid and ready output on both sides is 0. decouple_done=1, registered, asserted the cycle the state is entered. decouple=0 returns to RUN and drops decouple_done the same edge.
- While aresetn=0: all valid/ready outputs 0, decouple_done=0, counters and holds cleared. Reset mid-burst abandons in-flight transactions; both sides are assumed reset together.
- decouple asserted during reset: FSM goes RUN then DRAIN on the first edge after release.
- Counter at max: address ready held low until a decrement occurs. A decrement in the same cycle does not reopen ready; ready is based on the registered count only.

Test Plan:
- Pass-through: AW id=3 len=3 plus 4 W beats, slave B resp=OKAY; AR id=5 len=1 -> identical payloads downstream, zero latency, outst_w/outst_r return to 0, decouple_done stays 0.
- Outstanding limit: slave stalls B; master issues 9 AW len=0 with W -> exactly 8 accepted, awready=0 on the 9th. One B handshake -> 9th accepted on the following cycle.
- Drain: 2 reads len=7 in flight, decouple=1 -> arready=0 immediately; all 16 R beats delivered; decouple_done=1 the cycle after the final rlast handshake.
- Held valid: axi_m_awvalid=1 with awready=0 in the cycle decouple rises -> awvalid stays high until the slave accepts; W/B for that burst complete before decouple_done=1.
- Isolated: in DECOUPLED the master drives awvalid/arvalid/wvalid=1 for 20 cycles -> all readys 0 and all downstream valids 0. decouple=0 -> RUN next cycle, pending AW accepted.
- Reset during DRAIN with outst_r=3 -> after release: state RUN, counters 0, decouple_done=0.

Source files
------------

// File: rtl/axi4_mm_decoupler.sv
// AXI4-MM isolation stage: zero-latency pass-through in RUN, drains in-flight
// bursts on request, then fully isolates both sides until released.
module axi4_mm_decoupler #(
   parameter int AXI_ID_WIDTH     = 4,
   parameter int AXI_ADDR_WIDTH   = 32,
   parameter int AXI_DATA_WIDTH   = 32,
   parameter int OUTSTANDING_WREQ = 8,
   parameter int OUTSTANDING_RREQ = 8
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        decouple,
   output logic                        decouple_done,
   input  logic [AXI_ID_WIDTH-1:0]     axi_s_awid,
   input  logic [AXI_ADDR_WIDTH-1:0]   axi_s_awaddr,
   input  logic [7:0]                  axi_s_awlen,
   input  logic [2:0]                  axi_s_awsize,
   input  logic [1:0]                  axi_s_awburst,
   input  logic                        axi_s_awvalid,
   output logic                        axi_s_awready,
   input  logic [AXI_DATA_WIDTH-1:0]   axi_s_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] axi_s_wstrb,
   input  logic                        axi_s_wlast,
   input  logic                        axi_s_wvalid,
   output logic                        axi_s_wready,
   output logic [AXI_ID_WIDTH-1:0]     axi_s_bid,
   output logic [1:0]                  axi_s_bresp,
   output logic                        axi_s_bvalid,
   input  logic                        axi_s_bready,
   input  logic [AXI_ID_WIDTH-1:0]     axi_s_arid,
   input  logic [AXI_ADDR_WIDTH-1:0]   axi_s_araddr,
   input  logic [7:0]                  axi_s_arlen,
   input  logic [2:0]                  axi_s_arsize,
   input  logic [1:0]                  axi_s_arburst,
   input  logic                        axi_s_arvalid,
   output logic                        axi_s_arready,
   output logic [AXI_ID_WIDTH-1:0]     axi_s_rid,
   output logic [AXI_DATA_WIDTH-1:0]   axi_s_rdata,
   output logic [1:0]                  axi_s_rresp,
   output logic                        axi_s_rlast,
   output logic                        axi_s_rvalid,
   input  logic                        axi_s_rready,
   output logic [AXI_ID_WIDTH-1:0]     axi_m_awid,
   output logic [AXI_ADDR_WIDTH-1:0]   axi_m_awaddr,
   output logic [7:0]                  axi_m_awlen,
   output logic [2:0]                  axi_m_awsize,
   output logic [1:0]                  axi_m_awburst,
   output logic                        axi_m_awvalid,
   input  logic                        axi_m_awready,
   output logic [AXI_DATA_WIDTH-1:0]   axi_m_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] axi_m_wstrb,
   output logic                        axi_m_wlast,
   output logic                        axi_m_wvalid,
   input  logic                        axi_m_wready,
   input  logic [AXI_ID_WIDTH-1:0]     axi_m_bid,
   input  logic [1:0]                  axi_m_bresp,
   input  logic                        axi_m_bvalid,
   output logic                        axi_m_bready,
   output logic [AXI_ID_WIDTH-1:0]     axi_m_arid,
   output logic [AXI_ADDR_WIDTH-1:0]   axi_m_araddr,
   output logic [7:0]                  axi_m_arlen,
   output logic [2:0]                  axi_m_arsize,
   output logic [1:0]                  axi_m_arburst,
   output logic                        axi_m_arvalid,
   input  logic                        axi_m_arready,
   input  logic [AXI_ID_WIDTH-1:0]     axi_m_rid,
   input  logic [AXI_DATA_WIDTH-1:0]   axi_m_rdata,
   input  logic [1:0]                  axi_m_rresp,
   input  logic                        axi_m_rlast,
   input  logic                        axi_m_rvalid,
   output logic                        axi_m_rready
);
   // state     | meaning
   // RUN       | pass-through, new address beats accepted up to the limits
   // DRAIN     | no new address beats; in-flight bursts allowed to finish
   // DECOUPLED | every valid/ready forced low on both sides
   typedef enum logic [1:0] {RUN, DRAIN, DECOUPLED} state_t;

   localparam int WC_W = $clog2(OUTSTANDING_WREQ + 1);
   localparam int RC_W = $clog2(OUTSTANDING_RREQ + 1);
   localparam logic [WC_W-1:0] W_MAX = WC_W'(OUTSTANDING_WREQ);
   localparam logic [RC_W-1:0] R_MAX = RC_W'(OUTSTANDING_RREQ);

   state_t state, state_nxt;
   logic [WC_W-1:0] outst_w, outst_w_nxt, w_owed, w_owed_nxt;
   logic [RC_W-1:0] outst_r, outst_r_nxt;
   logic aw_hold, ar_hold, aw_hold_nxt, ar_hold_nxt;
   logic run_st, drain_st, live, aw_gate, ar_gate, w_gate;
   logic aw_hs, ar_hs, wlast_hs, b_hs, rlast_hs;

   assign axi_m_awid    = axi_s_awid;
   assign axi_m_awaddr  = axi_s_awaddr;
   assign axi_m_awlen   = axi_s_awlen;
   assign axi_m_awsize  = axi_s_awsize;
   assign axi_m_awburst = axi_s_awburst;
   assign axi_m_wdata   = axi_s_wdata;
   assign axi_m_wstrb   = axi_s_wstrb;
   assign axi_m_wlast   = axi_s_wlast;
   assign axi_s_bid     = axi_m_bid;
   assign axi_s_bresp   = axi_m_bresp;
   assign axi_m_arid    = axi_s_arid;
   assign axi_m_araddr  = axi_s_araddr;
   assign axi_m_arlen   = axi_s_arlen;
   assign axi_m_arsize  = axi_s_arsize;
   assign axi_m_arburst = axi_s_arburst;
   assign axi_s_rid     = axi_m_rid;
   assign axi_s_rdata   = axi_m_rdata;
   assign axi_s_rresp   = axi_m_rresp;
   assign axi_s_rlast   = axi_m_rlast;

   // Gated with aresetn so handshakes stay low even before the first reset edge.
   assign run_st   = aresetn && (state == RUN);
   assign drain_st = aresetn && (state == DRAIN);
   assign live     = run_st || drain_st;

   // A held address beat in DRAIN completes on both sides so it is neither lost nor duplicated.
   assign aw_gate = (run_st && (outst_w < W_MAX)) || (drain_st && aw_hold);
   assign ar_gate = (run_st && (outst_r < R_MAX)) || (drain_st && ar_hold);

   assign axi_m_awvalid = axi_s_awvalid && aw_gate;
   assign axi_s_awready = axi_m_awready && aw_gate;
   assign axi_m_arvalid = axi_s_arvalid && ar_gate;
   assign axi_s_arready = axi_m_arready && ar_gate;

   assign aw_hs  = axi_s_awvalid && axi_s_awready;
   assign ar_hs  = axi_s_arvalid && axi_s_arready;
   assign w_gate = live && ((w_owed != '0) || aw_hs);

   assign axi_m_wvalid = axi_s_wvalid && w_gate;
   assign axi_s_wready = axi_m_wready && w_gate;
   assign axi_s_bvalid = axi_m_bvalid && live;
   assign axi_m_bready = axi_s_bready && live;
   assign axi_s_rvalid = axi_m_rvalid && live;
   assign axi_m_rready = axi_s_rready && live;

   assign wlast_hs = axi_s_wvalid && axi_s_wready && axi_s_wlast;
   assign b_hs     = axi_s_bvalid && axi_s_bready;
   assign rlast_hs = axi_s_rvalid && axi_s_rready && axi_s_rlast;

   assign aw_hold_nxt = axi_m_awvalid && !axi_m_awready;
   assign ar_hold_nxt = axi_m_arvalid && !axi_m_arready;

   always_comb begin
      outst_w_nxt = outst_w;
      w_owed_nxt  = w_owed;
      outst_r_nxt = outst_r;
      if (aw_hs && !b_hs)      outst_w_nxt = outst_w + WC_W'(1);
      else if (!aw_hs && b_hs) outst_w_nxt = outst_w - WC_W'(1);
      if (aw_hs && !wlast_hs)      w_owed_nxt = w_owed + WC_W'(1);
      else if (!aw_hs && wlast_hs) w_owed_nxt = w_owed - WC_W'(1);
      if (ar_hs && !rlast_hs)      outst_r_nxt = outst_r + RC_W'(1);
      else if (!ar_hs && rlast_hs) outst_r_nxt = outst_r - RC_W'(1);
   end

   // Idle is judged on post-edge values so isolation starts right after the last handshake.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:       if (decouple) state_nxt = DRAIN;
         DRAIN: begin
            if (!decouple)
               state_nxt = RUN;
            else if (outst_w_nxt == '0 && w_owed_nxt == '0 && outst_r_nxt == '0 &&
                     !aw_hold_nxt && !ar_hold_nxt)
               state_nxt = DECOUPLED;
         end
         DECOUPLED: if (!decouple) state_nxt = RUN;
         default:   state_nxt = RUN;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state         <= RUN;
         decouple_done <= 1'b0;
         outst_w       <= '0;
         w_owed        <= '0;
         outst_r       <= '0;
         aw_hold       <= 1'b0;
         ar_hold       <= 1'b0;
      end else begin
         state         <= state_nxt;
         decouple_done <= (state_nxt == DECOUPLED);
         outst_w       <= outst_w_nxt;
         w_owed        <= w_owed_nxt;
         outst_r       <= outst_r_nxt;
         aw_hold       <= aw_hold_nxt;
         ar_hold       <= ar_hold_nxt;
      end
   end
endmodule

// File: tb/tb_axi4_mm_decoupler.sv
// Directed bench for axi4_mm_decoupler: pass-through, limits, drain, hold, isolation, reset.
module tb_axi4_mm_decoupler;
   logic aclk = 1'b0, aresetn, decouple, decouple_done;
   logic [3:0] s_awid, s_arid, s_bid, s_rid, m_awid, m_arid, m_bid, m_rid;
   logic [31:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
   logic [7:0] s_awlen, s_arlen, m_awlen, m_arlen;
   logic [2:0] s_awsize, s_arsize, m_awsize, m_arsize;
   logic [1:0] s_awburst, s_arburst, m_awburst, m_arburst, s_bresp, m_bresp, s_rresp, m_rresp;
   logic [31:0] s_wdata, m_wdata, s_rdata, m_rdata;
   logic [3:0] s_wstrb, m_wstrb;
   logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
   logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
   logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
   logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
   int total = 0, bad = 0;

   axi4_mm_decoupler dut (
      .aclk(aclk), .aresetn(aresetn), .decouple(decouple), .decouple_done(decouple_done),
      .axi_s_awid(s_awid), .axi_s_awaddr(s_awaddr), .axi_s_awlen(s_awlen), .axi_s_awsize(s_awsize),
      .axi_s_awburst(s_awburst), .axi_s_awvalid(s_awvalid), .axi_s_awready(s_awready),
      .axi_s_wdata(s_wdata), .axi_s_wstrb(s_wstrb), .axi_s_wlast(s_wlast), .axi_s_wvalid(s_wvalid),
      .axi_s_wready(s_wready), .axi_s_bid(s_bid), .axi_s_bresp(s_bresp), .axi_s_bvalid(s_bvalid),
      .axi_s_bready(s_bready), .axi_s_arid(s_arid), .axi_s_araddr(s_araddr), .axi_s_arlen(s_arlen),
      .axi_s_arsize(s_arsize), .axi_s_arburst(s_arburst), .axi_s_arvalid(s_arvalid),
      .axi_s_arready(s_arready), .axi_s_rid(s_rid), .axi_s_rdata(s_rdata), .axi_s_rresp(s_rresp),
      .axi_s_rlast(s_rlast), .axi_s_rvalid(s_rvalid), .axi_s_rready(s_rready),
      .axi_m_awid(m_awid), .axi_m_awaddr(m_awaddr), .axi_m_awlen(m_awlen), .axi_m_awsize(m_awsize),
      .axi_m_awburst(m_awburst), .axi_m_awvalid(m_awvalid), .axi_m_awready(m_awready),
      .axi_m_wdata(m_wdata), .axi_m_wstrb(m_wstrb), .axi_m_wlast(m_wlast), .axi_m_wvalid(m_wvalid),
      .axi_m_wready(m_wready), .axi_m_bid(m_bid), .axi_m_bresp(m_bresp), .axi_m_bvalid(m_bvalid),
      .axi_m_bready(m_bready), .axi_m_arid(m_arid), .axi_m_araddr(m_araddr), .axi_m_arlen(m_arlen),
      .axi_m_arsize(m_arsize), .axi_m_arburst(m_arburst), .axi_m_arvalid(m_arvalid),
      .axi_m_arready(m_arready), .axi_m_rid(m_rid), .axi_m_rdata(m_rdata), .axi_m_rresp(m_rresp),
      .axi_m_rlast(m_rlast), .axi_m_rvalid(m_rvalid), .axi_m_rready(m_rready)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
      m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
      s_wlast = 0; m_rlast = 0;
   endtask

   initial begin
      aresetn = 0; decouple = 0;
      idle_inputs();
      s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 3'd2; s_awburst = 2'd1;
      s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 3'd2; s_arburst = 2'd1;
      s_wdata = 0; s_wstrb = 4'hf; m_bid = 0; m_bresp = 0; m_rid = 0; m_rdata = 0; m_rresp = 0;
      tick(); tick();

      // reset: all handshakes gated low
      s_awvalid = 1; m_awready = 1; s_arvalid = 1; m_arready = 1; m_bvalid = 1; s_bready = 1;
      settle();
      chk("rst_ctl", {s_awready, m_awvalid, s_arready, m_arvalid, s_bvalid, m_bready, decouple_done}, 7'b0);
      idle_inputs();
      aresetn = 1;
      tick();

      // pass-through write: id=3 len=3
      s_awid = 4'd3; s_awaddr = 32'h1000_0040; s_awlen = 8'd3; s_awvalid = 1; m_awready = 1;
      s_wvalid = 1; s_wdata = 32'hA0A0_0000; s_wstrb = 4'h5; m_wready = 1;
      settle();
      chk("pt_aw_hs", {m_awvalid, s_awready, m_wvalid, s_wready}, 4'b1111);
      chk("pt_aw_pay", {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst}, {4'd3, 32'h1000_0040, 8'd3, 3'd2, 2'd1});
      chk("pt_w0_pay", {m_wdata, m_wstrb, m_wlast}, {32'hA0A0_0000, 4'h5, 1'b0});
      tick();
      s_awvalid = 0;
      for (int i = 1; i < 4; i++) begin
         s_wdata = 32'hA0A0_0000 + i; s_wlast = (i == 3);
         settle();
         chk("pt_w_beat", {m_wvalid, s_wready, m_wdata, m_wlast}, {2'b11, 32'hA0A0_0000 + i, i == 3});
         tick();
      end
      chk("pt_w_owed", {dut.outst_w, dut.w_owed}, {4'd1, 4'd0});
      s_wlast = 0;
      settle();
      chk("pt_w_blocked", {m_wvalid, s_wready}, 2'b00);
      s_wvalid = 0;
      m_bvalid = 1; m_bid = 4'd3; m_bresp = 2'b00; s_bready = 1;
      settle();
      chk("pt_b", {s_bvalid, m_bready, s_bid, s_bresp}, {2'b11, 4'd3, 2'b00});
      tick();
      m_bvalid = 0;
      // pass-through read: id=5 len=1
      s_arid = 4'd5; s_araddr = 32'h2000_0100; s_arlen = 8'd1; s_arvalid = 1; m_arready = 1;
      settle();
      chk("pt_ar", {m_arvalid, s_arready, m_arid, m_araddr, m_arlen}, {2'b11, 4'd5, 32'h2000_0100, 8'd1});
      tick();
      s_arvalid = 0; s_rready = 1; m_rvalid = 1; m_rid = 4'd5;
      for (int i = 0; i < 2; i++) begin
         m_rdata = 32'hD000_0000 + i; m_rlast = (i == 1);
         settle();
         chk("pt_r", {s_rvalid, m_rready, s_rid, s_rdata, s_rlast}, {2'b11, 4'd5, 32'hD000_0000 + i, i == 1});
         tick();
      end
      idle_inputs();
      settle();
      chk("pt_end", {dut.outst_w, dut.w_owed, dut.outst_r, decouple_done}, 13'b0);

      // outstanding write limit
      s_awlen = 8'd0; m_awready = 1; m_wready = 1; s_bready = 1; s_wlast = 1;
      for (int i = 0; i < 8; i++) begin
         s_awvalid = 1; s_wvalid = 1; s_awid = 4'(i);
         settle();
         chk("lim_accept", {s_awready, s_wready}, 2'b11);
         tick();
      end
      settle();
      chk("lim_full", {s_awready, m_awvalid, s_wready, m_wvalid}, 4'b0000);
      m_bvalid = 1; m_bid = 4'd0;
      settle();
      chk("lim_same_cycle", {s_awready, s_bvalid}, 2'b01);
      tick();
      m_bvalid = 0;
      settle();
      chk("lim_reopen", {s_awready, m_awvalid, s_wready}, 3'b111);
      tick();
      s_awvalid = 0; s_wvalid = 0;
      settle();
      chk("lim_cnt8", {dut.outst_w, dut.w_owed}, {4'd8, 4'd0});
      m_bvalid = 1;
      for (int i = 0; i < 8; i++) tick();
      idle_inputs();
      settle();
      chk("lim_drained", dut.outst_w, 0);

      // drain two len=7 reads
      s_arlen = 8'd7; m_arready = 1; s_arvalid = 1;
      s_arid = 4'd1; tick();
      s_arid = 4'd2; tick();
      s_arvalid = 0; decouple = 1;
      tick();
      s_arvalid = 1;
      settle();
      chk("dr_ar_block", {s_arready, m_arvalid}, 2'b00);
      s_rready = 1; m_rvalid = 1;
      for (int i = 0; i < 16; i++) begin
         m_rlast = (i == 7) || (i == 15);
         settle();
         chk("dr_r_beat", {s_rvalid, m_rready, decouple_done}, 3'b110);
         tick();
      end
      m_rvalid = 0; m_rlast = 0;
      settle();
      chk("dr_done", {decouple_done, dut.outst_r}, {1'b1, 4'd0});

      // isolated for 20 cycles
      s_awvalid = 1; s_wvalid = 1; s_wlast = 1; s_arvalid = 1; s_bready = 1; s_rready = 1;
      m_awready = 1; m_wready = 1; m_arready = 1; m_bvalid = 1; m_rvalid = 1;
      s_arlen = 8'd0;
      for (int i = 0; i < 20; i++) begin
         settle();
         chk("iso", {decouple_done, s_awready, s_arready, s_wready, m_bready, m_rready,
                     m_awvalid, m_arvalid, m_wvalid, s_bvalid, s_rvalid}, 11'b100_0000_0000);
         tick();
      end
      m_bvalid = 0; m_rvalid = 0; decouple = 0;
      tick();
      settle();
      chk("iso_release", {decouple_done, s_awready, m_awvalid, s_arready, s_wready}, 5'b01111);
      tick();
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
      m_bvalid = 1; tick(); m_bvalid = 0;
      m_rvalid = 1; m_rlast = 1; tick();
      idle_inputs();
      settle();
      chk("iso_clean", {dut.outst_w, dut.w_owed, dut.outst_r}, 12'b0);

      // held AW when decouple rises
      s_awid = 4'd7; s_awlen = 8'd1; s_awvalid = 1; decouple = 1;
      settle();
      chk("hold_first", {m_awvalid, s_awready}, 2'b10);
      tick();
      chk("hold_drain1", {m_awvalid, s_awready}, 2'b10);
      tick();
      chk("hold_drain2", {m_awvalid, s_awready, decouple_done}, 3'b100);
      m_awready = 1;
      settle();
      chk("hold_accept", {m_awvalid, s_awready}, 2'b11);
      tick();
      s_awvalid = 0; m_awready = 0; m_wready = 1; s_wvalid = 1;
      for (int i = 0; i < 2; i++) begin
         s_wlast = (i == 1);
         settle();
         chk("hold_w", {m_wvalid, s_wready, decouple_done}, 3'b110);
         tick();
      end
      s_wvalid = 0; s_wlast = 0;
      settle();
      chk("hold_wait_b", decouple_done, 1'b0);
      m_bvalid = 1; m_bid = 4'd7; s_bready = 1;
      settle();
      chk("hold_b", {s_bvalid, s_bid}, {1'b1, 4'd7});
      tick();
      m_bvalid = 0;
      settle();
      chk("hold_done", decouple_done, 1'b1);
      decouple = 0;
      tick();
      chk("hold_release", decouple_done, 1'b0);
      idle_inputs();

      // reset during DRAIN with three reads outstanding
      s_arvalid = 1; m_arready = 1;
      tick(); tick(); tick();
      s_arvalid = 0; decouple = 1;
      tick();
      chk("rst_pre", {dut.outst_r, s_arready}, {4'd3, 1'b0});
      aresetn = 0; decouple = 0; s_arvalid = 1;
      settle();
      chk("rst_gated", {s_arready, m_arvalid}, 2'b00);
      tick();
      aresetn = 1;
      settle();
      chk("rst_after", {decouple_done, dut.outst_r, s_arready, m_arvalid}, {1'b0, 4'd0, 2'b11});
      s_arvalid = 0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
